// File: rtl/pcs_pkg.sv
// Shared 10GBASE-R PCS definitions: widths, sync header codes, gearbox sequencing.
package pcs_pkg;

  localparam int DATA_WIDTH      = 32;
  localparam int HEADER_WIDTH    = 2;
  localparam int GEARBOX_SEQ_MAX = 32;

  // Internal gearbox geometry: a 64-bit holding buffer and a 6-bit counter of valid bits.
  localparam int SEQ_WIDTH = 6;
  localparam int BUF_WIDTH = 64;
  localparam int CNT_WIDTH = 6;

  typedef logic [HEADER_WIDTH-1:0] sync_header_t;

  localparam sync_header_t SYNC_DATA = 2'b01;
  localparam sync_header_t SYNC_CTRL = 2'b10;

  // What the gearbox does with the upstream word in a given sequence slot.
  typedef enum logic [1:0] {
    WORD_FIRST  = 2'd0,  // header + first payload word of a block
    WORD_SECOND = 2'd1,  // second payload word of a block
    WORD_PAUSE  = 2'd2   // nothing consumed, buffer drains
  } word_kind_t;

  // Decode a sequence slot into the kind of word accepted there.
  function automatic word_kind_t word_kind(input logic [SEQ_WIDTH-1:0] seq);
    if (seq == SEQ_WIDTH'(GEARBOX_SEQ_MAX)) return WORD_PAUSE;
    else if (!seq[0])                       return WORD_FIRST;
    else                                    return WORD_SECOND;
  endfunction

endpackage

// File: rtl/tx_gearbox.sv
// TX 66b->32b gearbox: packs {data1, data0, header} blocks into a continuous 32-bit
// stream (LSB first) and pauses upstream for one cycle out of every 33.
module tx_gearbox
  import pcs_pkg::*;
#(
  parameter int DATA_WIDTH   = pcs_pkg::DATA_WIDTH,
  parameter int HEADER_WIDTH = pcs_pkg::HEADER_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    init_done,
  input  logic [HEADER_WIDTH-1:0] i_header,
  input  logic [DATA_WIDTH-1:0]   i_data,
  output logic [DATA_WIDTH-1:0]   o_data,
  output logic                    o_pause,
  output logic                    o_first_word,
  output logic [SEQ_WIDTH-1:0]    o_seq
);

  // The datapath below is written for a 32-bit word and a 2-bit header only.
  if (DATA_WIDTH != 32) begin : g_bad_data_width
    $error("tx_gearbox: only DATA_WIDTH=32 is supported");
  end
  if (HEADER_WIDTH != 2) begin : g_bad_header_width
    $error("tx_gearbox: only HEADER_WIDTH=2 is supported");
  end

  logic [SEQ_WIDTH-1:0]  seq_q;
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic [BUF_WIDTH-1:0]  buffer_q;
  logic [DATA_WIDTH-1:0] data_q;

  word_kind_t            kind;
  logic [BUF_WIDTH-1:0]  insert;
  logic [BUF_WIDTH-1:0]  merged;
  logic [CNT_WIDTH:0]    total;   // valid bits after insert, 0..64

  assign kind = word_kind(seq_q);

  // Place the accepted word (with header on a block's first word) above the bits
  // already held, and compute how many bits are valid before the output takes 32.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    insert = '0;
    total  = {1'b0, cnt_q};
    unique case (kind)
      WORD_FIRST: begin
        insert = BUF_WIDTH'({i_data, i_header}) << cnt_q;
        total  = {1'b0, cnt_q} + 7'd34;
      end
      WORD_SECOND: begin
        insert = BUF_WIDTH'(i_data) << cnt_q;
        total  = {1'b0, cnt_q} + 7'd32;
      end
      default: ;
    endcase
    merged = buffer_q | insert;
  end

  // Sequence counter: 0..32 while running, frozen at 0 while the transceiver is not ready.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      seq_q <= '0;
    end else if (!init_done) begin
      seq_q <= '0;
    end else if (seq_q == SEQ_WIDTH'(GEARBOX_SEQ_MAX)) begin
      seq_q <= '0;
    end else begin
      seq_q <= seq_q + 1'b1;
    end
  end

  // Holding buffer and output register: emit the low 32 bits, keep the rest for next cycle.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: the buffer is cleared on reset/init so a discarded partial block never leaks out.
    if (reset) begin
      buffer_q <= '0;
      cnt_q    <= '0;
      data_q   <= '0;
    end else if (!init_done) begin
      buffer_q <= '0;
      cnt_q    <= '0;
      data_q   <= '0;
    end else begin
      data_q   <= merged[DATA_WIDTH-1:0];
      buffer_q <= {{DATA_WIDTH{1'b0}}, merged[BUF_WIDTH-1:DATA_WIDTH]};
      cnt_q    <= CNT_WIDTH'(total - 7'd32);
    end
  end

  assign o_data       = data_q;
  assign o_pause      = (kind == WORD_PAUSE);
  assign o_first_word = (kind == WORD_FIRST);
  assign o_seq        = seq_q;

  // Every output word must be fully populated; running short means the sequence is broken.
  a_no_underrun : assert property (
    @(posedge clk) disable iff (reset || !init_done) total >= 7'd32
  );

  // The bit count only ever advances by even amounts.
  a_cnt_even : assert property (
    @(posedge clk) disable iff (reset) !cnt_q[0]
  );

endmodule

// File: tb/tb_tx_gearbox.sv
// Randomised bench for tx_gearbox against a bit-queue model of the 66b->32b stream.
module tb_tx_gearbox;

  logic        clk;
  logic        reset;
  logic        init_done;
  logic [1:0]  i_header;
  logic [31:0] i_data;
  logic [31:0] o_data;
  logic        o_pause;
  logic        o_first_word;
  logic [5:0]  o_seq;

  tx_gearbox dut (
    .clk          (clk),
    .reset        (reset),
    .init_done    (init_done),
    .i_header     (i_header),
    .i_data       (i_data),
    .o_data       (o_data),
    .o_pause      (o_pause),
    .o_first_word (o_first_word),
    .o_seq        (o_seq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;

  // Model state: slot index within the 33-cycle period, and the serial bit stream
  // that has been accepted but not yet emitted.
  int m_seq = 0;
  bit bits_q[$];
  int pause_seen = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: check decoded outputs, drive inputs, advance model, check o_data.
  task automatic run_cycle(input logic en, input logic [1:0] h, input logic [31:0] d);
    logic [31:0] exp_w;
    @(negedge clk);
    check("seq",        64'(o_seq),        64'(m_seq));
    check("pause",      64'(o_pause),      64'(m_seq == 32));
    check("first_word", 64'(o_first_word), 64'((m_seq % 2 == 0) && (m_seq != 32)));
    if (o_pause) pause_seen++;
    init_done = en;
    if (m_seq != 32) begin
      i_header = h;
      i_data   = d;
    end
    exp_w = '0;
    if (en) begin
      if (m_seq != 32) begin
        if (m_seq % 2 == 0) begin
          bits_q.push_back(h[0]);
          bits_q.push_back(h[1]);
        end
        for (int i = 0; i < 32; i++) bits_q.push_back(d[i]);
      end
      for (int i = 0; i < 32; i++) exp_w[i] = (bits_q.size() > 0) ? bits_q.pop_front() : 1'b0;
      m_seq = (m_seq == 32) ? 0 : m_seq + 1;
    end else begin
      bits_q.delete();
      m_seq = 0;
    end
    @(posedge clk);
    #1;
    check("data", 64'(o_data), 64'(exp_w));
  endtask

  task automatic run_random(input int n);
    for (int i = 0; i < n; i++) run_cycle(1'b1, 2'($urandom_range(0, 3)), $urandom);
  endtask

  // Asynchronous reset pulse placed between clock edges; outputs must clear at once.
  task automatic reset_pulse();
    #1 reset = 1'b1;
    #1;
    check("rst_data",  64'(o_data),       64'd0);
    check("rst_seq",   64'(o_seq),        64'd0);
    check("rst_pause", 64'(o_pause),      64'd0);
    check("rst_first", 64'(o_first_word), 64'd1);
    bits_q.delete();
    m_seq = 0;
    reset = 1'b0;
  endtask

  logic [31:0] ctrl_words [33];
  logic [1:0]  h0;
  logic [31:0] exp_rule;

  initial begin
    reset     = 1'b1;
    init_done = 1'b0;
    i_header  = '0;
    i_data    = '0;
    #3;
    check("init_data",  64'(o_data),       64'd0);
    check("init_seq",   64'(o_seq),        64'd0);
    check("init_pause", 64'(o_pause),      64'd0);
    check("init_first", 64'(o_first_word), 64'd1);
    #9 reset = 1'b0;

    // Directed first word, then free-run: 200 cycles from seq 0 contain 6 pauses.
    pause_seen = 0;
    run_cycle(1'b1, 2'b01, 32'hFFFF_FFFF);
    check("first_out", 64'(o_data), 64'h0000_0000_FFFF_FFFD);
    run_random(199);
    check("pause_count", 64'(pause_seen), 64'd6);

    // Async reset in the middle of a block at seq 17, then restart with a header.
    for (int i = 0; i < 40 && m_seq != 17; i++) run_random(1);
    check("at_seq17", 64'(o_seq), 64'd17);
    reset_pulse();
    h0 = 2'($urandom_range(0, 3));
    run_cycle(1'b1, h0, $urandom);
    check("restart_hdr", 64'(o_data[1:0]), 64'(h0));
    run_random(40);

    // All-zero control blocks from seq 0: header '1' bits land at offsets 66*b+1 only.
    reset_pulse();
    for (int w = 0; w < 33; w++) begin
      run_cycle(1'b1, 2'b10, 32'h0);
      ctrl_words[w] = o_data;
    end
    for (int w = 0; w < 33; w++) begin
      for (int b = 0; b < 32; b++) exp_rule[b] = (((w * 32 + b) % 66) == 1);
      check("ctrl_stream", 64'(ctrl_words[w]), 64'(exp_rule));
    end
    check("ctrl_period_seq", 64'(o_seq), 64'd0);

    // init_done dropped mid-stream for 10 cycles, then a clean restart.
    run_random(20);
    for (int i = 0; i < 10; i++) run_cycle(1'b0, 2'($urandom_range(0, 3)), $urandom);
    h0 = 2'($urandom_range(0, 3));
    run_cycle(1'b1, h0, $urandom);
    check("resume_hdr", 64'(o_data[1:0]), 64'(h0));
    run_random(80);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    n_bad++;
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
